// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared NES bus constants and the OAM DMA state type (ALIGN exists only with OAM_DMA_ALIGN_EN).
package nes_bus_pkg;
  localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
`ifdef OAM_DMA_ALIGN_EN
    ST_ALIGN,
`endif
    ST_READ,
    ST_WRITE
  } oam_dma_state_t;
endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side snoop and DMA bus-master signals of the OAM DMA block.
interface oam_dma_if;
  logic        clk_ph1;
  logic        clk_ph2;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_r_nw;
  logic [7:0]  bus_din;
  logic        cpu_halt;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_r_nw;
  modport master (
    output clk_ph1, clk_ph2, cpu_addr, cpu_dout, cpu_r_nw, bus_din,
    input  cpu_halt, dma_active, dma_addr, dma_dout, dma_r_nw
  );
  modport slave (
    input  clk_ph1, clk_ph2, cpu_addr, cpu_dout, cpu_r_nw, bus_din,
    output cpu_halt, dma_active, dma_addr, dma_dout, dma_r_nw
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: $4014-triggered 256-byte copy from {page,idx} to $2004; OAM_DMA_ALIGN_EN adds the odd-cycle ALIGN stall.
module oam_dma
  import nes_bus_pkg::*;
(
  input logic      sys_clock,
  input logic      rst,
  oam_dma_if.slave bus
);
  oam_dma_state_t state, nxt;
  logic       pending, parity;
  logic [7:0] idx, nidx, page, data_buf;
  always_comb begin
    nxt = state;
    nidx = idx;
    if (bus.clk_ph1)
      case (state)
        ST_IDLE: begin
          nxt = pending ? ST_HALT : ST_IDLE;
          nidx = pending ? 8'h00 : idx;
        end
`ifdef OAM_DMA_ALIGN_EN
        ST_HALT:  nxt = parity ? ST_ALIGN : ST_READ;
        ST_ALIGN: nxt = ST_READ;
`else
        ST_HALT:  nxt = ST_READ;
`endif
        ST_READ:  nxt = ST_WRITE;
        ST_WRITE: begin
          nxt = (idx == 8'hFF) ? ST_IDLE : ST_READ;
          nidx = idx + 8'd1;
        end
        default:  nxt = ST_IDLE;
      endcase
  end
`ifndef OAM_DMA_ALIGN_EN
  logic unused_parity;
  assign unused_parity = parity;
`endif
  // Outputs are registered from the next state so they change exactly on phase-1 boundaries.
  always_ff @(posedge sys_clock)
    if (!rst) begin
      state <= ST_IDLE;
      pending <= 1'b0;
      parity <= 1'b0;
      idx <= 8'h00;
      page <= 8'h00;
      data_buf <= 8'h00;
      bus.cpu_halt <= 1'b0;
      bus.dma_active <= 1'b0;
      bus.dma_r_nw <= 1'b1;
      bus.dma_addr <= 16'h0000;
      bus.dma_dout <= 8'h00;
    end else begin
      if (bus.clk_ph1) begin
        state <= nxt;
        idx <= nidx;
        parity <= ~parity;
        if (state == ST_IDLE) pending <= 1'b0;
        bus.cpu_halt <= nxt != ST_IDLE;
        bus.dma_active <= nxt == ST_READ || nxt == ST_WRITE;
        bus.dma_r_nw <= nxt != ST_WRITE;
        bus.dma_addr <= nxt == ST_READ ? {page, nidx} : nxt == ST_WRITE ? OAMDATA_ADDR : 16'h0000;
        bus.dma_dout <= nxt == ST_WRITE ? data_buf : 8'h00;
      end
      if (bus.clk_ph2 && state == ST_READ) data_buf <= bus.bus_din;
      if (bus.clk_ph2 && state == ST_IDLE && !pending && bus.cpu_addr == OAM_DMA_ADDR && !bus.cpu_r_nw) begin
        page <= bus.cpu_dout;
        pending <= 1'b1;
      end
    end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: random-memory OAM DMA transfers checked against an expected copy list built from the source page.
module tb_oam_dma;
  import nes_bus_pkg::*;
  logic sys_clock = 1'b0;
  logic rst = 1'b0;
  oam_dma_if ifc();
  oam_dma dut (.sys_clock(sys_clock), .rst(rst), .bus(ifc));
  always #5 sys_clock = ~sys_clock;
  logic [7:0] mem [65536];
  assign ifc.bus_din = mem[ifc.dma_addr];
  int checks = 0, errors = 0;
  logic [15:0] rd_q [$];
  logic [7:0]  wr_q [$];
  int bad_wr_addr = 0, halt_run = 0, last_run = 0, done_cnt = 0, edges = 0, start_par = 0, last_par = 0;

  always @(posedge sys_clock)
    if (!rst) edges <= 0;
    else if (ifc.clk_ph1) edges <= edges + 1;

  // CPU cycle = 4 sys_clock edges: ph1 edge, then ph2 edge two clocks later; bus activity logged once per cycle.
  initial begin
    int c;
    c = 0;
    ifc.clk_ph1 = 1'b0;
    ifc.clk_ph2 = 1'b0;
    forever begin
      @(negedge sys_clock);
      ifc.clk_ph1 = (c == 0);
      ifc.clk_ph2 = (c == 2);
      if (c == 2) begin
        if (ifc.dma_active && ifc.dma_r_nw) rd_q.push_back(ifc.dma_addr);
        if (ifc.dma_active && !ifc.dma_r_nw) begin
          wr_q.push_back(ifc.dma_dout);
          if (ifc.dma_addr !== OAMDATA_ADDR) bad_wr_addr++;
        end
        if (ifc.cpu_halt) begin
          if (halt_run == 0) start_par = edges % 2;
          halt_run++;
        end else if (halt_run != 0) begin
          last_run = halt_run;
          last_par = start_par;
          halt_run = 0;
          done_cnt++;
        end
      end
      c = (c + 1) % 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_acc(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    @(posedge sys_clock);
    #1;
    ifc.cpu_addr = a;
    ifc.cpu_dout = d;
    ifc.cpu_r_nw = rnw;
    repeat (4) @(posedge sys_clock);
    #1;
    ifc.cpu_addr = 16'h0000;
    ifc.cpu_dout = 8'h00;
    ifc.cpu_r_nw = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_halt"}, ifc.cpu_halt, 1'b0);
    chk({tag, "_active"}, ifc.dma_active, 1'b0);
    chk({tag, "_rnw"}, ifc.dma_r_nw, 1'b1);
    chk({tag, "_addr"}, ifc.dma_addr, 16'h0000);
    chk({tag, "_dout"}, ifc.dma_dout, 8'h00);
  endtask

  task automatic transfer(input logic [7:0] p, input bit retrig, input string tag);
    int prev, n, exp_len;
    logic [7:0] ii;
    rd_q.delete();
    wr_q.delete();
    bad_wr_addr = 0;
    prev = done_cnt;
    cpu_acc(OAM_DMA_ADDR, p, 1'b0);
    if (retrig) begin
      n = 0;
      while (rd_q.size() < 17 && n < 4000) begin
        @(posedge sys_clock);
        n++;
      end
      chk({tag, "_reach_idx10"}, rd_q.size() >= 17, 1'b1);
      cpu_acc(OAM_DMA_ADDR, 8'h07, 1'b0);
    end
    n = 0;
    while (done_cnt == prev && n < 4000) begin
      @(posedge sys_clock);
      n++;
    end
    chk({tag, "_done"}, done_cnt != prev, 1'b1);
`ifdef OAM_DMA_ALIGN_EN
    exp_len = 513 + last_par;
`else
    exp_len = 513;
`endif
    chk({tag, "_halt_len"}, last_run, exp_len);
    chk({tag, "_reads"}, rd_q.size(), 256);
    chk({tag, "_writes"}, wr_q.size(), 256);
    chk({tag, "_wr_addr"}, bad_wr_addr, 0);
    for (int i = 0; i < 256; i++) begin
      ii = i[7:0];
      if (i < rd_q.size()) chk({tag, "_rd"}, rd_q[i], {p, ii});
      if (i < wr_q.size()) chk({tag, "_wr"}, wr_q[i], mem[{p, ii}]);
    end
    repeat (40) @(posedge sys_clock);
    #1;
    check_idle({tag, "_end"});
    chk({tag, "_no_restart"}, done_cnt, prev + 1);
    chk({tag, "_no_extra_reads"}, rd_q.size(), 256);
  endtask

  initial begin
    int n;
    logic [7:0] ii;
    ifc.cpu_addr = 16'h0000;
    ifc.cpu_dout = 8'h00;
    ifc.cpu_r_nw = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (8) @(posedge sys_clock);
    #1;
    check_idle("reset");
    rst = 1'b1;
    cpu_acc(OAM_DMA_ADDR, 8'h02, 1'b1);
    cpu_acc(16'h4015, 8'h02, 1'b0);
    repeat (40) @(posedge sys_clock);
    #1;
    chk("nontrig_halt", ifc.cpu_halt, 1'b0);
    chk("nontrig_run", halt_run + done_cnt, 0);
    for (int i = 0; i < 256; i++) begin
      ii = i[7:0];
      mem[{8'h02, ii}] = ii ^ 8'hA5;
    end
    transfer(8'h02, 1'b1, "basic_retrig");
    transfer(8'($urandom_range(1, 254)), 1'b0, "rand_page");
    transfer(8'h40, 1'b0, "page40");
    transfer(8'hFF, 1'b0, "pageFF");
    transfer(8'($urandom_range(1, 254)), 1'b0, "rand_page2");
    rd_q.delete();
    wr_q.delete();
    cpu_acc(OAM_DMA_ADDR, 8'h05, 1'b0);
    n = 0;
    while (rd_q.size() < 129 && n < 4000) begin
      @(posedge sys_clock);
      n++;
    end
    chk("midrst_reach_idx80", rd_q.size() >= 129, 1'b1);
    #1;
    rst = 1'b0;
    @(posedge sys_clock);
    #1;
    chk("midrst_halt", ifc.cpu_halt, 1'b0);
    chk("midrst_active", ifc.dma_active, 1'b0);
    chk("midrst_rnw", ifc.dma_r_nw, 1'b1);
    chk("midrst_addr", ifc.dma_addr, 16'h0000);
    rst = 1'b1;
    n = rd_q.size();
    repeat (40) @(posedge sys_clock);
    #1;
    chk("midrst_quiet_reads", rd_q.size(), n);
    chk("midrst_quiet_halt", ifc.cpu_halt, 1'b0);
    transfer(8'h03, 1'b0, "after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL provide `sys_clock`, an input of width 1, which is the system clock; all state changes on its rising edge.
REQ-002 The block SHALL provide `rst`, an input of width 1, which is the reset; it is synchronous and active-low.
REQ-003 The block SHALL provide `clk_ph1`, an input of width 1, which is the CPU phase-1 enable; a DMA cycle boundary occurs at each `sys_clock` edge where `clk_ph1`=1.
REQ-004 The block SHALL provide `clk_ph2`, an input of width 1, which is the CPU phase-2 enable; data capture occurs at each edge where `clk_ph2`=1.
REQ-005 The block SHALL provide `cpu_addr`, an input of width 16, which is the CPU address bus.
REQ-006 The block SHALL provide `cpu_dout`, an input of width 8, which is the CPU output data bus.
REQ-007 The block SHALL provide `cpu_r_nw`, an input of width 1, which is the CPU read/not-write.
REQ-008 The block SHALL provide `bus_din`, an input of width 8, which is the read data returned from the system memory map.
REQ-009 The block SHALL provide `cpu_halt`, an output of width 1; while it is 1, system logic withholds the CPU phase enables.
REQ-010 The block SHALL provide `dma_active`, an output of width 1; while it is 1, the system bus mux selects the DMA address, data and R/nW over the CPU's.
REQ-011 The block SHALL provide `dma_addr`, an output of width 16, which is the DMA address.
REQ-012 The block SHALL provide `dma_dout`, an output of width 8, which is the DMA write data.
REQ-013 The block SHALL provide `dma_r_nw`, an output of width 1, which is the DMA read/not-write.

Function
REQ-014 Trigger: at a `clk_ph2` edge with `cpu_addr`=16'h4014 and `cpu_r_nw`=0, the block SHALL latch `cpu_dout` as `page` and set `pending`, provided the state is IDLE.
REQ-015 A trigger write while the state is not IDLE SHALL be ignored: `page` is unchanged and no restart occurs.
REQ-016 The states SHALL be IDLE, HALT, ALIGN, READ and WRITE; all transitions occur only on `clk_ph1` edges.
REQ-017 In IDLE, if `pending` is set, the block SHALL move to HALT, clear `pending`, clear the 8-bit `idx`, and assert `cpu_halt`.
REQ-018 In HALT, the block SHALL move to ALIGN if alignment applies (REQ-033), otherwise to READ.
REQ-019 ALIGN SHALL be a dummy cycle: `dma_active`=0 and the next state is READ.
REQ-020 In READ, the block SHALL drive `dma_active`=1, `dma_addr`={`page`,`idx`} and `dma_r_nw`=1; at the `clk_ph2` edge in READ it latches `bus_din` into `buf`.
REQ-021 In WRITE, the block SHALL drive `dma_active`=1, `dma_addr`=16'h2004, `dma_r_nw`=0 and `dma_dout`=`buf`.
REQ-022 At the end of WRITE, the block SHALL wrap-increment `idx`; if `idx` was 8'hFF, the next state is IDLE, otherwise READ.
REQ-023 The block SHALL deassert `cpu_halt` on the `clk_ph1` edge entering IDLE.
REQ-024 `cpu_halt` SHALL be 1 for exactly 513 cycles without ALIGN and 514 cycles with ALIGN.
REQ-025 Exactly 256 read/write pairs SHALL occur, with source addresses {`page`,8'h00} through {`page`,8'hFF} in ascending order.
REQ-026 `page`=8'h40 (self-referencing I/O) SHALL be transferred verbatim with no special casing.
REQ-027 All outputs SHALL be registered; outside READ/WRITE they hold `dma_active`=0, `dma_r_nw`=1, `dma_addr`=16'h0000, `dma_dout`=8'h00.
REQ-028 Simultaneous trigger and IDLE exit SHALL not occur; the trigger is checked only in IDLE (REQ-015).
REQ-029 An internal `parity` bit SHALL toggle on every `clk_ph1` edge, including during halt.

Reset
REQ-030 `rst`=0 at any edge SHALL force IDLE and clear `pending`, `idx`, `page`, `buf` and `parity`.
REQ-031 On reset, the outputs SHALL take their REQ-027 values and `cpu_halt`=0; reset mid-transfer aborts it with no further bus cycles.

Configuration
REQ-032 The macro SHALL be `OAM_DMA_ALIGN_EN`.
REQ-033 With `OAM_DMA_ALIGN_EN` defined, ALIGN SHALL be entered from HALT when `parity`=1, giving a halt of 514 cycles; otherwise ALIGN is skipped.
REQ-034 With `OAM_DMA_ALIGN_EN` undefined, ALIGN SHALL be never entered, the state is not synthesised, and the halt is always 513 cycles.

Structure
REQ-035 The shared package `nes_bus_pkg` SHALL hold the constants `OAM_DMA_ADDR`=16'h4014 and `OAMDATA_ADDR`=16'h2004, and the `oam_dma_state_t` enum.
REQ-036 The block SHALL have no sub-module: a single FSM plus the `idx` counter, `parity` bit and registers.

Verification
REQ-037 Basic transfer: reset, then CPU writes 8'h02 to $4014, with memory $0200+i = i^8'hA5 and `OAM_DMA_ALIGN_EN` undefined -> 256 writes to $2004 with data i^8'hA5 in order, and `cpu_halt` high for 513 cycles.
REQ-038 Alignment: with `OAM_DMA_ALIGN_EN` defined, trigger so that `parity`=1 at HALT -> ALIGN present and halt lasts 514 cycles; trigger with `parity`=0 -> halt lasts 513 cycles.
REQ-039 Ignored retrigger: a second $4014 write of 8'h07 forced during `idx`=8'h10 -> it is ignored, and the source page stays 8'h02 through $02FF.
REQ-040 Reset mid-transfer: `rst`=0 at `idx`=8'h80 -> the next cycle shows `cpu_halt`=0, `dma_active`=0, `dma_r_nw`=1; a fresh 8'h03 trigger then transfers from $0300.
REQ-041 Non-trigger accesses: a read of $4014 and a write of $4015 -> no `pending` set and `cpu_halt` stays 0.
REQ-042 Wrap-around: page 8'hFF -> the last source address is $FFFF, `idx` wraps to 8'h00, the block is IDLE, and no access to $0000 occurs.
